nibble_stream_arbiter: RTL

Packet-granular round-robin arbiter sharing one nibble repacker between NUM_SRC AXI-stream producers. Each granted packet passes unmodified to the repacker's slave port. The arbiter loads the repacker's frame-length input (mem) from a per-source config word, then sequences the read phase (rd_en) until the repacker signals drain completion. It also checks each packet's accumulated keep total against the configured length.

---
 rtl/nibble_pkg.sv | 25 ++
 rtl/nibble_stream_arbiter_if.sv | 30 +++
 rtl/nibble_stream_arbiter_rr_pick.sv | 26 ++
 rtl/nibble_stream_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble arbiter and repacker.
// Keep is counted in bits: valid nibbles times NIBBLE_W.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  localparam int KEEP_N0 = 0;
  localparam int KEEP_N1 = 4;
  localparam int KEEP_N2 = 8;
  localparam int KEEP_N3 = 12;
  localparam int KEEP_N4 = 16;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } arb_state_t;

  function automatic logic keep_legal(input int k);
    return (k == KEEP_N0) || (k == KEEP_N1) ||
           (k == KEEP_N2) || (k == KEEP_N3) ||
           (k == KEEP_N4);
  endfunction

endpackage

// File: rtl/nibble_stream_arbiter_if.sv
// Arbiter-to-repacker link: stream beats plus frame length
// and read-phase sequencing.
interface nibble_stream_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 8,
  parameter int LEN_W  = 12
);

  logic [DATA_W-1:0] m_data;
  logic [KEEP_W-1:0] m_keep;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic [LEN_W-1:0]  mem;
  logic              rd_en;
  logic              drain_done;

  modport master (
    output m_data, m_keep, m_valid, m_last,
    output mem, rd_en,
    input  m_ready, drain_done
  );

  modport slave (
    input  m_data, m_keep, m_valid, m_last,
    input  mem, rd_en,
    output m_ready, drain_done
  );

endinterface

// File: rtl/nibble_stream_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester after
// last_grant, wrapping modulo NUM_SRC.
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         last_grant,
  output logic [2:0]         idx,
  output logic               found
);

  always_comb begin
    int c;
    c = 0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      c = (int'(last_grant) + k) % NUM_SRC;
      if (!found && req[c]) begin
        found = 1'b1;
        idx = 3'(c);
      end
    end
  end

endmodule

// File: rtl/nibble_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one nibble
// repacker; sequences its read phase and checks keep totals.
module nibble_stream_arbiter
  import nibble_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 16,
  parameter int KEEP_W  = 8,
  parameter int LEN_W   = 12
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC*KEEP_W-1:0] s_keep,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [NUM_SRC-1:0]        s_last,
  output logic [NUM_SRC-1:0]        s_ready,
  input  logic [NUM_SRC*LEN_W-1:0]  cfg_len,
  nibble_stream_arbiter_if.master   rp,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      keep_err,
  output logic                      len_err
);

  arb_state_t        state;
  logic [2:0]        last_grant;
  logic [LEN_W-1:0]  acc;
  logic [LEN_W-1:0]  mem_q;
  logic              rd_q;

  logic [2:0]        pick_idx;
  logic              pick_found;
  logic [LEN_W-1:0]  pick_len;

  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_valid;
  logic              sel_last;

  logic              xfer;
  logic              beat;
  logic [LEN_W:0]    sum;

  rr_pick #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .req       (s_valid),
    .last_grant,
    .idx       (pick_idx),
    .found     (pick_found)
  );

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    pick_len  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 3'(i)) begin
        sel_data  = s_data[i*DATA_W +: DATA_W];
        sel_keep  = s_keep[i*KEEP_W +: KEEP_W];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
      if (pick_idx == 3'(i)) begin
        pick_len = cfg_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign xfer = (state == XFER);

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = xfer && (grant_id == 3'(i))
                   && rp.m_ready;
    end
  end

  assign rp.m_data  = sel_data;
  assign rp.m_keep  = sel_keep;
  assign rp.m_valid = xfer & sel_valid;
  assign rp.m_last  = sel_last;
  assign rp.mem     = mem_q;
  assign rp.rd_en   = rd_q;

  assign beat = rp.m_valid & rp.m_ready;
  // Unsaturated total so an overflowing packet still mismatches.
  assign sum  = {1'b0, acc} + (LEN_W+1)'(sel_keep);

  always_ff @(posedge clk) begin
    if (!arst) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_SRC-1);
      grant_id   <= '0;
      mem_q      <= '0;
      acc        <= '0;
      rd_q       <= 1'b0;
      busy       <= 1'b0;
      keep_err   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      keep_err <= 1'b0;
      len_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            mem_q    <= pick_len;
            acc      <= '0;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            acc      <= sum[LEN_W] ? '1 : sum[LEN_W-1:0];
            keep_err <= !keep_legal(int'(sel_keep));
            if (sel_last) begin
              len_err <= (sum != {1'b0, mem_q});
              rd_q    <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rp.drain_done) begin
            last_grant <= grant_id;
            rd_q       <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
